// File: rtl/axi3_metrics_pkg.sv
// Shared constants and event type for the AXI3 transaction tracker and metrics counter.
package axi3_metrics_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned ERR_WR_OVF = 0;
    localparam int unsigned ERR_RD_OVF = 1;
    localparam int unsigned ERR_ORPHAN = 2;
    localparam int unsigned ERR_ORDER  = 3;

    // Widest latency field carried by an event; trackers zero-extend into it.
    localparam int unsigned EVT_LAT_W = 64;

    typedef struct packed {
        logic [EVT_LAT_W-1:0] lat;
        logic [4:0]           beats;
        logic                 resp_err;
    } evt_t;

endpackage

// File: rtl/axi3_ts_fifo.sv
// Synchronous FIFO of issue records; a push while full is taken only if a pop happens too.
module axi3_ts_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/axi3_txn_tracker.sv
// Passive AXI3 snoop: matches AW/AR issues to B/final-R in order and emits latency events.
// Define AXI3_TXN_TRACKER_RESP_CHECK_EN to report non-OKAY responses in *_evt_resp_err.
module axi3_txn_tracker
    import axi3_metrics_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 32,
    parameter int unsigned ID_W  = 6
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            awvalid,
    input  logic            awready,
    input  logic [ID_W-1:0] awid,
    input  logic [3:0]      awlen,
    input  logic            arvalid,
    input  logic            arready,
    input  logic [ID_W-1:0] arid,
    input  logic [3:0]      arlen,
    input  logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            rvalid,
    input  logic            rready,
    input  logic            rlast,
    input  logic [ID_W-1:0] rid,
    input  logic [1:0]      rresp,
    input  logic            err_clr,
    output logic            wr_evt_valid,
    output logic [TS_W-1:0] wr_evt_lat,
    output logic [4:0]      wr_evt_beats,
    output logic            wr_evt_resp_err,
    output logic            rd_evt_valid,
    output logic [TS_W-1:0] rd_evt_lat,
    output logic [4:0]      rd_evt_beats,
    output logic            rd_evt_resp_err,
    output logic [3:0]      err
);
    // Entry layout: {issue timestamp, id, beat count}
    localparam int unsigned ENT_W = TS_W + ID_W + 5;

    logic [TS_W-1:0]  ts_q;
    logic [4:0]       rbeats_q, rd_beats;
    logic [3:0]       err_q, err_set;
    logic             wr_vld_q, rd_vld_q;
    evt_t             wr_evt_q, rd_evt_q;
    logic             aw_hs, ar_hs, b_hs, r_hs, rl_hs;
    logic             wr_full, wr_empty, rd_full, rd_empty, wr_pop, rd_pop;
    logic [ENT_W-1:0] wr_head, rd_head;
    logic             wr_resp_err, rd_resp_err;

    assign aw_hs    = awvalid & awready;
    assign ar_hs    = arvalid & arready;
    assign b_hs     = bvalid & bready;
    assign r_hs     = rvalid & rready;
    assign rl_hs    = r_hs & rlast;
    assign wr_pop   = b_hs & ~wr_empty;
    assign rd_pop   = rl_hs & ~rd_empty;
    assign rd_beats = rbeats_q + 5'd1;

    axi3_ts_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_wr_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (aw_hs),
        .pop   (b_hs),
        .wdata ({ts_q, awid, 5'(awlen) + 5'd1}),
        .rdata (wr_head),
        .full  (wr_full),
        .empty (wr_empty)
    );

    axi3_ts_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_rd_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (ar_hs),
        .pop   (rl_hs),
        .wdata ({ts_q, arid, 5'(arlen) + 5'd1}),
        .rdata (rd_head),
        .full  (rd_full),
        .empty (rd_empty)
    );

    always_comb begin
        err_set = '0;
        err_set[ERR_WR_OVF] = aw_hs & wr_full & ~wr_pop;
        err_set[ERR_RD_OVF] = ar_hs & rd_full & ~rd_pop;
        err_set[ERR_ORPHAN] = (b_hs & wr_empty) | (rl_hs & rd_empty);
        err_set[ERR_ORDER]  = (wr_pop & (bid != wr_head[ID_W+4:5]))
                            | (rd_pop & ((rid != rd_head[ID_W+4:5]) | (rd_beats != rd_head[4:0])));
    end

`ifdef AXI3_TXN_TRACKER_RESP_CHECK_EN
    logic rerr_q;

    assign wr_resp_err = (bresp != RESP_OKAY);
    assign rd_resp_err = rerr_q | (rresp != RESP_OKAY);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)     rerr_q <= 1'b0;
        else if (rl_hs) rerr_q <= 1'b0;
        else if (r_hs)  rerr_q <= rd_resp_err;
    end
`else
    logic unused_resp;

    assign unused_resp = ^{bresp, rresp};
    assign wr_resp_err = 1'b0;
    assign rd_resp_err = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ts_q     <= '0;
            rbeats_q <= '0;
            err_q    <= '0;
            wr_vld_q <= 1'b0;
            rd_vld_q <= 1'b0;
            wr_evt_q <= '0;
            rd_evt_q <= '0;
        end else begin
            ts_q     <= ts_q + TS_W'(1);
            err_q    <= (err_clr ? 4'b0 : err_q) | err_set;
            wr_vld_q <= wr_pop;
            rd_vld_q <= rd_pop;
            if (rl_hs)     rbeats_q <= '0;
            else if (r_hs) rbeats_q <= rd_beats;
            if (wr_pop) begin
                wr_evt_q.lat      <= EVT_LAT_W'(ts_q - wr_head[ENT_W-1 -: TS_W]);
                wr_evt_q.beats    <= wr_head[4:0];
                wr_evt_q.resp_err <= wr_resp_err;
            end
            if (rd_pop) begin
                rd_evt_q.lat      <= EVT_LAT_W'(ts_q - rd_head[ENT_W-1 -: TS_W]);
                rd_evt_q.beats    <= rd_beats;
                rd_evt_q.resp_err <= rd_resp_err;
            end
        end
    end

    if (TS_W < EVT_LAT_W) begin : g_lat_pad
        logic unused_lat_hi;
        assign unused_lat_hi = ^{wr_evt_q.lat[EVT_LAT_W-1:TS_W], rd_evt_q.lat[EVT_LAT_W-1:TS_W]};
    end

    assign wr_evt_valid    = wr_vld_q;
    assign wr_evt_lat      = wr_evt_q.lat[TS_W-1:0];
    assign wr_evt_beats    = wr_evt_q.beats;
    assign wr_evt_resp_err = wr_evt_q.resp_err;
    assign rd_evt_valid    = rd_vld_q;
    assign rd_evt_lat      = rd_evt_q.lat[TS_W-1:0];
    assign rd_evt_beats    = rd_evt_q.beats;
    assign rd_evt_resp_err = rd_evt_q.resp_err;
    assign err             = err_q;

endmodule
